// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared grid constants, FSM/direction enums and cell type for the snake game
package snake_pkg;

  localparam int CELL_SHIFT = 4;
  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int MAX_LEN    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_MOVE,
    ST_RELOCATE,
    ST_OVER
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
  } cell_t;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:   return DIR_DOWN;
      DIR_DOWN: return DIR_UP;
      DIR_LEFT: return DIR_RIGHT;
      default:  return DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_lfsr.sv
// rtl/snake_lfsr.sv - free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) for apple placement
module snake_lfsr (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] value_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_o <= 16'hACE1;
    end else begin
      value_o <= {value_o[14:0], value_o[15] ^ value_o[13] ^ value_o[12] ^ value_o[10]};
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game FSM, segment store, collision/apple logic and pixel lookup
module snake_game_ctrl #(
  parameter int CELL_SHIFT  = 4,
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int MAX_LEN     = 16,
  parameter int STEP_FRAMES = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       frame_tick_i,
  input  logic [9:0] pix_x_i,
  input  logic [9:0] pix_y_i,
  output logic       head_snake_gfx_o,
  output logic       body_snake_gfx_o,
  output logic       apple_gfx_o,
  output logic       border_gfx_o,
  output logic       game_over_o,
  output logic [7:0] score_o
);
  import snake_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_t           state;
  dir_t             dir;
  dir_t             dir_req;
  cell_t            seg [MAX_LEN];
  cell_t            seg_init [MAX_LEN];
  cell_t            apple;
  cell_t            apple_init;
  logic [LEN_W-1:0] len;
  logic [2:0]       frame_cnt;
  logic [15:0]      lfsr;

  snake_lfsr u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .value_o (lfsr)
  );

  function automatic logic on_border(input cell_t c);
    return (c.x == 6'd0) || (c.x == 6'(GRID_W - 1)) ||
           (c.y == 5'd0) || (c.y == 5'(GRID_H - 1));
  endfunction

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) seg_init[i] = '0;
    seg_init[0] = '{x: 6'd20, y: 5'd15};
    seg_init[1] = '{x: 6'd19, y: 5'd15};
    seg_init[2] = '{x: 6'd18, y: 5'd15};
    apple_init  = '{x: 6'd30, y: 5'd15};
  end

  // Highest-priority pressed button wins; a reversal onto the neck is dropped.
  dir_t req_dir;
  logic req_accept;
  always_comb begin
    req_accept = 1'b1;
    req_dir    = dir;
    if (btn_up_i)         req_dir = DIR_UP;
    else if (btn_down_i)  req_dir = DIR_DOWN;
    else if (btn_left_i)  req_dir = DIR_LEFT;
    else if (btn_right_i) req_dir = DIR_RIGHT;
    else                  req_accept = 1'b0;
    if (req_dir == opposite(dir)) req_accept = 1'b0;
  end

  cell_t next_head;
  logic  hit_self;
  logic  collide;
  always_comb begin
    next_head = seg[0];
    case (dir_req)
      DIR_UP:   next_head.y = seg[0].y - 5'd1;
      DIR_DOWN: next_head.y = seg[0].y + 5'd1;
      DIR_LEFT: next_head.x = seg[0].x - 6'd1;
      default:  next_head.x = seg[0].x + 6'd1;
    endcase
    // The tail vacates its cell on this move, so it cannot be hit.
    hit_self = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if ((i + 1 < int'(len)) && (seg[i] == next_head)) hit_self = 1'b1;
    collide = hit_self || on_border(next_head);
  end

  cell_t cand;
  logic  cand_hit;
  logic  cand_ok;
  always_comb begin
    cand.x   = 6'((lfsr & 16'h003F) % 16'(GRID_W));
    cand.y   = 5'(((lfsr >> 8) & 16'h001F) % 16'(GRID_H));
    cand_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if ((i < int'(len)) && (seg[i] == cand)) cand_hit = 1'b1;
    cand_ok = !cand_hit && !on_border(cand);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      dir         <= DIR_RIGHT;
      dir_req     <= DIR_RIGHT;
      seg         <= seg_init;
      apple       <= apple_init;
      len         <= LEN_W'(3);
      frame_cnt   <= 3'd0;
      score_o     <= 8'd0;
      game_over_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            dir       <= DIR_RIGHT;
            dir_req   <= DIR_RIGHT;
            seg       <= seg_init;
            apple     <= apple_init;
            len       <= LEN_W'(3);
            frame_cnt <= 3'd0;
            score_o   <= 8'd0;
            state     <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (req_accept) dir_req <= req_dir;
          if (frame_tick_i) begin
            if (frame_cnt >= 3'(STEP_FRAMES - 2)) begin
              frame_cnt <= 3'd0;
              state     <= ST_MOVE;
            end else begin
              frame_cnt <= frame_cnt + 3'd1;
            end
          end
        end
        ST_MOVE: begin
          dir <= dir_req;
          if (collide) begin
            game_over_o <= 1'b1;
            state       <= ST_OVER;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) seg[i] <= seg[i-1];
            seg[0] <= next_head;
            if (next_head == apple) begin
              if (len < LEN_W'(MAX_LEN)) len <= len + LEN_W'(1);
              if (score_o != 8'hFF) score_o <= score_o + 8'd1;
              state <= ST_RELOCATE;
            end else begin
              state <= ST_PLAY;
            end
          end
        end
        ST_RELOCATE: begin
          // Ticks keep accumulating but cap one short of overflow; PLAY fires the move on the next tick.
          if (frame_tick_i && frame_cnt != 3'(STEP_FRAMES - 1)) frame_cnt <= frame_cnt + 3'd1;
          if (cand_ok) begin
            apple <= cand;
            state <= ST_PLAY;
          end
        end
        ST_OVER: begin
          if (!start_i) begin
            game_over_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [9:0] cx;
  logic [9:0] cy;
  cell_t      pcell;
  logic       in_grid;
  logic       pix_head;
  logic       pix_body;
  always_comb begin
    cx       = pix_x_i >> CELL_SHIFT;
    cy       = pix_y_i >> CELL_SHIFT;
    in_grid  = (cx < 10'(GRID_W)) && (cy < 10'(GRID_H));
    pcell.x  = cx[5:0];
    pcell.y  = cy[4:0];
    pix_head = (seg[0] == pcell);
    pix_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if ((i < int'(len)) && (seg[i] == pcell)) pix_body = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_snake_gfx_o <= 1'b0;
      body_snake_gfx_o <= 1'b0;
      apple_gfx_o      <= 1'b0;
      border_gfx_o     <= 1'b0;
    end else begin
      head_snake_gfx_o <= in_grid && pix_head;
      body_snake_gfx_o <= in_grid && !pix_head && pix_body;
      apple_gfx_o      <= in_grid && (pcell == apple);
      border_gfx_o     <= in_grid && on_border(pcell);
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - directed self-checking bench for snake_game_ctrl
module tb_snake_game_ctrl;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic       head_gfx, body_gfx, apple_gfx, border_gfx, game_over;
  logic [7:0] score;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  snake_game_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .btn_up_i         (btn_up),
    .btn_down_i       (btn_down),
    .btn_left_i       (btn_left),
    .btn_right_i      (btn_right),
    .frame_tick_i     (frame_tick),
    .pix_x_i          (pix_x),
    .pix_y_i          (pix_y),
    .head_snake_gfx_o (head_gfx),
    .body_snake_gfx_o (body_gfx),
    .apple_gfx_o      (apple_gfx),
    .border_gfx_o     (border_gfx),
    .game_over_o      (game_over),
    .score_o          (score)
  );

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start_game;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
    end
  endtask

  task automatic wait_settle;
    int n = 0;
    while (!(dut.state == ST_PLAY || dut.state == ST_OVER) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL settle timeout state=%0d", dut.state); end
  endtask

  task automatic step;
    tick_n(7);
    wait_settle();
  endtask

  task automatic probe_px(input int px, input int py, output logic [3:0] g);
    @(posedge clk); #1 pix_x = 10'(px); pix_y = 10'(py);
    @(posedge clk); #1 g = {head_gfx, body_gfx, apple_gfx, border_gfx};
  endtask

  task automatic probe_cell(input int cx, input int cy, output logic [3:0] g);
    probe_px(cx * 16 + 8, cy * 16 + 8, g);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, ST_IDLE); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got=%0d exp=0", score); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got=%b exp=0", game_over); end
    checks++; if ({head_gfx, body_gfx, apple_gfx, border_gfx} !== 4'b0000) begin
      errors++; $display("FAIL reset_gfx got=%b exp=0000", {head_gfx, body_gfx, apple_gfx, border_gfx}); end
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr got=%h exp=ace1", dut.lfsr); end
    #1 rst = 1'b0;
  endtask

  task automatic test_pixel_lookup;
    logic [3:0] g;
    do_reset();
    probe_px(328, 248, g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL pix_head got=%b exp=1000", g); end
    probe_px(0, 0, g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL pix_border got=%b exp=0001", g); end
    probe_px(488, 248, g);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL pix_apple got=%b exp=0010", g); end
    probe_px(650, 100, g);
    checks++; if (g !== 4'b0000) begin errors++; $display("FAIL pix_off_grid got=%b exp=0000", g); end
    probe_cell(18, 15, g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL pix_tail got=%b exp=0100", g); end
    probe_cell(17, 15, g);
    checks++; if (g !== 4'b0000) begin errors++; $display("FAIL pix_beyond_tail got=%b exp=0000", g); end
  endtask

  task automatic test_first_step;
    logic [3:0] g;
    do_reset();
    start_game();
    tick_n(8);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dut.state !== ST_PLAY) begin errors++; $display("FAIL step_state got=%0d exp=%0d", dut.state, ST_PLAY); end
    probe_cell(21, 15, g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL step_head got=%b exp=1000", g); end
    probe_cell(19, 15, g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL step_body got=%b exp=0100", g); end
    probe_cell(18, 15, g);
    checks++; if (g !== 4'b0000) begin errors++; $display("FAIL step_old_tail got=%b exp=0000", g); end
  endtask

  task automatic test_direction;
    logic [3:0] g;
    do_reset();
    start_game();
    btn_left = 1'b1;
    step();
    btn_left = 1'b0;
    probe_cell(21, 15, g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL dir_reverse_head got=%b exp=1000", g); end
    do_reset();
    start_game();
    btn_up = 1'b1;
    step();
    btn_up = 1'b0;
    probe_cell(20, 14, g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL dir_up_head got=%b exp=1000", g); end
    probe_cell(20, 15, g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL dir_up_neck got=%b exp=0100", g); end
    probe_cell(21, 15, g);
    checks++; if (g !== 4'b0000) begin errors++; $display("FAIL dir_up_right_empty got=%b exp=0000", g); end
  endtask

  task automatic test_eat_apple;
    logic [3:0] g;
    int heads = 0, bodies = 0, apples = 0, bad_apple = 0;
    do_reset();
    start_game();
    repeat (9) step();
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL eat_score_before got=%0d exp=0", score); end
    step();
    checks++; if (score !== 8'd1) begin errors++; $display("FAIL eat_score got=%0d exp=1", score); end
    for (int y = 0; y < 30; y++) begin
      for (int x = 0; x < 40; x++) begin
        probe_cell(x, y, g);
        if (g[3]) heads++;
        if (g[2]) bodies++;
        if (g[1]) begin
          apples++;
          if (g[3] || g[2] || g[0]) bad_apple++;
        end
      end
    end
    checks++; if (heads != 1) begin errors++; $display("FAIL eat_head_count got=%0d exp=1", heads); end
    checks++; if (bodies != 3) begin errors++; $display("FAIL eat_body_count got=%0d exp=3", bodies); end
    checks++; if (apples != 1) begin errors++; $display("FAIL eat_apple_count got=%0d exp=1", apples); end
    checks++; if (bad_apple != 0) begin errors++; $display("FAIL eat_apple_placement got=%0d exp=0", bad_apple); end
    probe_cell(30, 15, g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL eat_head_on_old_apple got=%b exp=1000", g); end
    probe_cell(27, 15, g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL eat_grown_tail got=%b exp=0100", g); end
  endtask

  task automatic test_wall_collision;
    logic [3:0] g;
    do_reset();
    start_game();
    repeat (18) step();
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL wall_not_over got=%b exp=0", game_over); end
    tick_n(6);
    start = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL wall_over_in_move got=%b exp=0", game_over); end
    @(posedge clk); #1;
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL wall_over got=%b exp=1", game_over); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dut.state !== ST_OVER) begin errors++; $display("FAIL wall_hold_over got=%0d exp=%0d", dut.state, ST_OVER); end
    probe_cell(38, 15, g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL wall_frozen_head got=%b exp=1000", g); end
    probe_cell(39, 15, g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL wall_border_cell got=%b exp=0001", g); end
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (dut.state !== ST_IDLE || game_over !== 1'b0) begin
      errors++; $display("FAIL wall_to_idle got=%0d/%b exp=%0d/0", dut.state, game_over, ST_IDLE); end
    start_game();
    checks++; if (dut.state !== ST_PLAY || score !== 8'd0) begin
      errors++; $display("FAIL wall_restart got=%0d/%0d exp=%0d/0", dut.state, score, ST_PLAY); end
    probe_cell(20, 15, g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL wall_restart_head got=%b exp=1000", g); end
    probe_cell(38, 15, g);
    checks++; if (g !== 4'b0000) begin errors++; $display("FAIL wall_restart_clear got=%b exp=0000", g); end
  endtask

  task automatic test_reset_in_move;
    logic [3:0] g;
    cell_t exp_head;
    exp_head = '{x: 6'd20, y: 5'd15};
    do_reset();
    start_game();
    repeat (10) step();
    tick_n(6);
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    checks++; if (dut.state !== ST_MOVE) begin errors++; $display("FAIL rmove_in_move got=%0d exp=%0d", dut.state, ST_MOVE); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL rmove_state got=%0d exp=%0d", dut.state, ST_IDLE); end
    checks++; if (dut.len !== 5'd3) begin errors++; $display("FAIL rmove_len got=%0d exp=3", dut.len); end
    checks++; if (score !== 8'd0 || game_over !== 1'b0) begin
      errors++; $display("FAIL rmove_score_over got=%0d/%b exp=0/0", score, game_over); end
    checks++; if ({head_gfx, body_gfx, apple_gfx, border_gfx} !== 4'b0000) begin
      errors++; $display("FAIL rmove_gfx got=%b exp=0000", {head_gfx, body_gfx, apple_gfx, border_gfx}); end
    checks++; if (dut.lfsr !== 16'hACE1 || dut.frame_cnt !== 3'd0) begin
      errors++; $display("FAIL rmove_lfsr_cnt got=%h/%0d exp=ace1/0", dut.lfsr, dut.frame_cnt); end
    checks++; if (dut.seg[0] !== exp_head) begin errors++; $display("FAIL rmove_seg0 got=%h exp=%h", dut.seg[0], exp_head); end
    rst = 1'b0;
    probe_cell(30, 15, g);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL rmove_apple got=%b exp=0010", g); end
  endtask

  initial begin
    test_reset();
    test_pixel_lookup();
    test_first_step();
    test_direction();
    test_eat_apple();
    test_wall_collision();
    test_reset_in_move();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
